// File: rtl/uart_click_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_click_tx                                          |
// | Description : Serialises local click pulses into 8N1 click frames    |
// |               (LSB first, idle high) for the peer board's remote     |
// |               click receiver. Clicks that arrive while a frame is    |
// |               on the wire are queued up to MAX_PENDING deep; any     |
// |               further click is dropped and flagged for one cycle.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_click_tx #(
  parameter int         CLK_FREQ    = 65_000_000,
  parameter int         BAUD        = 115_200,
  parameter logic [7:0] CLICK_BYTE  = 8'hC1,
  parameter int         MAX_PENDING = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               click,
  output logic                               tx_out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               dropped
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int PEND_W       = $clog2(MAX_PENDING + 1);

  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PEND_W-1:0] C_PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] C_PEND_ONE = PEND_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

  // A bit period shorter than two clocks cannot hold a stable line level.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_click_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (MAX_PENDING < 1) begin : g_bad_depth
      $error("uart_click_tx: MAX_PENDING must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_baud_cnt;
  logic [2:0]         r_bit_idx;

  logic               w_bit_end;
  logic               w_has_pending;
  logic [PEND_W-1:0]  w_queue_next;
  logic               w_queue_drop;

  assign w_bit_end     = (r_baud_cnt == C_CNT_LAST);
  assign w_has_pending = (pending != '0);

  // Queue update for a click that arrives while a frame is in flight and
  // no frame is being launched on this edge: count it or drop it.
  always_comb begin
    w_queue_next = pending;
    w_queue_drop = 1'b0;
    if (click) begin
      if (pending == C_PEND_MAX) begin
        w_queue_drop = 1'b1;
      end else begin
        w_queue_next = pending + C_PEND_ONE;
      end
    end
  end

  // Frame sequencer: all outputs registered, baud counter cleared on every
  // bit boundary so each bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      pending    <= '0;
      dropped    <= 1'b0;
    end else begin
      dropped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          if (click || w_has_pending) begin
            // A fresh click launches directly; a queued click launches and
            // is consumed, unless a new click replaces it on the same edge.
            r_state <= ST_START;
            tx_out  <= 1'b0;
            busy    <= 1'b1;
            if (w_has_pending && !click) begin
              pending <= pending - C_PEND_ONE;
            end
          end else begin
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        end

        ST_START: begin
          pending <= w_queue_next;
          dropped <= w_queue_drop;
          if (w_bit_end) begin
            r_state    <= ST_DATA;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            tx_out     <= CLICK_BYTE[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
          end
        end

        ST_DATA: begin
          pending <= w_queue_next;
          dropped <= w_queue_drop;
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              tx_out  <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              tx_out    <= CLICK_BYTE[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            if (w_has_pending) begin
              // Back-to-back launch: a click on this edge replaces the one
              // consumed, so it can never overflow the queue.
              r_state <= ST_START;
              tx_out  <= 1'b0;
              if (!click) begin
                pending <= pending - C_PEND_ONE;
              end
            end else begin
              // Queue empty: go idle; a click here is queued and launches
              // on the following edge.
              r_state <= ST_IDLE;
              busy    <= 1'b0;
              pending <= click ? C_PEND_ONE : '0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
            pending    <= w_queue_next;
            dropped    <= w_queue_drop;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          tx_out  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_click_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_click_tx                                       |
// | Description : Self-checking bench for uart_click_tx (10 clk/bit).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_click_tx;

  localparam int FRAME = 100;   // 10 bits x 10 clocks
  localparam int QMAX  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       click;
  logic       tx_out;
  logic       busy;
  logic [1:0] pending;
  logic       dropped;

  uart_click_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .CLICK_BYTE (8'hC1),
    .MAX_PENDING(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .click  (click),
    .tx_out (tx_out),
    .busy   (busy),
    .pending(pending),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Free-running edge counter used to timestamp events relative to a test.
  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // Tracks only when the current frame started and how many clicks wait;
  // the line level follows from the time elapsed since the frame start.
  logic [7:0] exp_byte = 8'hC1;
  bit  m_valid = 1'b0;
  int  m_edge  = 0;
  int  m_start = -1;
  int  m_pend  = 0;
  bit  m_drop  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_start = -1;
      m_pend  = 0;
      m_drop  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_edge++;
      m_drop = 1'b0;
      if (m_start >= 0 && m_edge - m_start >= FRAME) begin
        if (m_pend > 0) begin
          m_start = m_edge;
          m_pend  = m_pend - 1 + int'(click);
        end else begin
          m_start = -1;
          m_pend  = int'(click);
        end
      end else if (m_start >= 0) begin
        if (click) begin
          if (m_pend < QMAX) m_pend++;
          else m_drop = 1'b1;
        end
      end else if (click || m_pend > 0) begin
        m_start = m_edge;
        if (!click) m_pend--;
      end
    end
  end

  function automatic int m_tx();
    int k;
    if (m_start < 0) return 1;
    k = (m_edge - m_start) / 10;
    if (k == 0) return 0;
    if (k <= 8) return int'(exp_byte[k-1]);
    return 1;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("model tx_out",  int'(tx_out),  m_tx());
      check("model busy",    int'(busy),    (m_start >= 0) ? 1 : 0);
      check("model pending", int'(pending), m_pend);
      check("model dropped", int'(dropped), int'(m_drop));
    end
  end

  // ---------------- reference UART receiver ----------------
  int dec_phase = 0;
  int dec_cnt   = 0;
  int dec_start = 0;
  bit dec_bad   = 1'b0;
  logic [7:0] dec_byte = 8'h00;
  int dec_bytes[$];
  int dec_starts[$];

  always @(negedge clk) begin
    if (rst) begin
      dec_phase = 0;
    end else if (dec_phase == 0) begin
      if (tx_out == 1'b0) begin
        dec_phase = 1;
        dec_cnt   = 0;
        dec_bad   = 1'b0;
        dec_start = cyc - base;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == 5 && tx_out != 1'b0) dec_bad = 1'b1;
      if (dec_cnt >= 15 && dec_cnt <= 85 && (dec_cnt - 15) % 10 == 0)
        dec_byte = {tx_out, dec_byte[7:1]};
      if (dec_cnt == 95) begin
        if (tx_out != 1'b1) dec_bad = 1'b1;
        dec_bytes.push_back(dec_bad ? -1 : int'(dec_byte));
        dec_starts.push_back(dec_start);
        dec_phase = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int   sched[$];
  logic hist_tx   [0:1023];
  logic hist_busy [0:1023];
  logic hist_drop [0:1023];
  int   hist_pend [0:1023];

  task automatic start_test();
    base = cyc;
    dec_bytes.delete();
    dec_starts.delete();
    sched.delete();
  endtask

  // Called at a negedge; hist[r] is the output state after edge base+r,
  // and a click scheduled at r is sampled on edge base+r+1.
  task automatic run(input int n);
    for (int r = 0; r < n; r++) begin
      hist_tx[r]   = tx_out;
      hist_busy[r] = busy;
      hist_drop[r] = dropped;
      hist_pend[r] = int'(pending);
      click = 1'b0;
      foreach (sched[i]) if (sched[i] == r) click = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    click = 1'b0;
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -2;
  endfunction

  function automatic int count_hi(input int which, input int lo, input int hi);
    int s = 0;
    for (int r = lo; r <= hi; r++) begin
      if (which == 0 && hist_busy[r]) s++;
      if (which == 1 && hist_drop[r]) s++;
      if (which == 2 && !hist_tx[r]) s++;
    end
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    click = 1'b0;
    repeat (3) @(negedge clk);

    // T1: asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("t1 tx_out",  int'(tx_out),  1);
    check("t1 busy",    int'(busy),    0);
    check("t1 pending", int'(pending), 0);
    check("t1 dropped", int'(dropped), 0);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    start_test();
    run(30);
    check("t1 line low cycles", count_hi(2, 0, 29), 0);

    // T2: single click
    start_test();
    sched = '{100};
    run(230);
    check("t2 frames",      dec_bytes.size(), 1);
    check("t2 byte",        qat(dec_bytes, 0), 8'hC1);
    check("t2 start",       qat(dec_starts, 0), 101);
    check("t2 busy cycles", count_hi(0, 0, 229), 100);
    check("t2 busy@100",    int'(hist_busy[100]), 0);
    check("t2 busy@201",    int'(hist_busy[201]), 0);
    check("t2 tx start",    int'(hist_tx[101]), 0);
    check("t2 tx@110",      int'(hist_tx[110]), 0);
    check("t2 tx bit0",     int'(hist_tx[111]), 1);
    check("t2 tx bit1",     int'(hist_tx[121]), 0);
    check("t2 tx bit5",     int'(hist_tx[161]), 0);
    check("t2 tx bit6",     int'(hist_tx[171]), 1);
    check("t2 tx bit7",     int'(hist_tx[181]), 1);
    check("t2 tx stop",     int'(hist_tx[191]), 1);

    // T3: burst of three
    start_test();
    sched = '{100, 105, 110};
    run(420);
    check("t3 pend@105", hist_pend[105], 0);
    check("t3 pend@106", hist_pend[106], 1);
    check("t3 pend@111", hist_pend[111], 2);
    check("t3 pend@201", hist_pend[201], 1);
    check("t3 pend@301", hist_pend[301], 0);
    check("t3 frames",   dec_bytes.size(), 3);
    check("t3 start0",   qat(dec_starts, 0), 101);
    check("t3 start1",   qat(dec_starts, 1), 201);
    check("t3 start2",   qat(dec_starts, 2), 301);
    check("t3 byte2",    qat(dec_bytes, 2), 8'hC1);
    check("t3 drops",    count_hi(1, 0, 419), 0);

    // T4: overflow
    start_test();
    sched = '{0, 10, 20, 30, 40};
    run(420);
    check("t4 pend@31",  hist_pend[31], 3);
    check("t4 pend@41",  hist_pend[41], 3);
    check("t4 drop@41",  int'(hist_drop[41]), 1);
    check("t4 drops",    count_hi(1, 0, 419), 1);
    check("t4 frames",   dec_bytes.size(), 4);
    check("t4 start3",   qat(dec_starts, 3), 301);

    // T5a: click on the STOP-end edge with two queued
    start_test();
    sched = '{0, 5, 10, 100};
    run(420);
    check("t5a pend@100", hist_pend[100], 2);
    check("t5a pend@101", hist_pend[101], 2);
    check("t5a busy@101", int'(hist_busy[101]), 1);
    check("t5a frames",   dec_bytes.size(), 4);
    check("t5a start1",   qat(dec_starts, 1), 101);
    check("t5a start3",   qat(dec_starts, 3), 301);
    check("t5a drops",    count_hi(1, 0, 419), 0);

    // T5b: click on the STOP->IDLE edge
    start_test();
    sched = '{0, 100};
    run(220);
    check("t5b busy@101", int'(hist_busy[101]), 0);
    check("t5b pend@101", hist_pend[101], 1);
    check("t5b pend@102", hist_pend[102], 0);
    check("t5b busy@102", int'(hist_busy[102]), 1);
    check("t5b frames",   dec_bytes.size(), 2);
    check("t5b start1",   qat(dec_starts, 1), 102);

    // T6: reset during data bit 4
    start_test();
    sched = '{0, 10, 20};
    run(55);
    check("t6 pend before", hist_pend[54], 2);
    check("t6 tx before",   int'(hist_tx[54]), 0);
    #2 rst = 1'b1;
    #1;
    check("t6 tx_out",  int'(tx_out),  1);
    check("t6 pending", int'(pending), 0);
    check("t6 busy",    int'(busy),    0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    start_test();
    sched = '{5};
    run(130);
    check("t6 line low pre", count_hi(2, 0, 5), 0);
    check("t6 frames",       dec_bytes.size(), 1);
    check("t6 start",        qat(dec_starts, 0), 6);
    check("t6 byte",         qat(dec_bytes, 0), 8'hC1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_click_tx.md
Name: uart_click_tx

Overview:
- Transmit side of the two-board link: turns local mouse-click pulses into serial click frames on a pin wired to the peer board's remote-click receive input.
- Sits between the local click edge detector (1-cycle pulse in the 65 MHz domain) and the board pin.
- Queues a small number of clicks so bursts are never merged. Frame format matches the peer receiver: 8N1, LSB first, idle high.

Parameters:
- CLK_FREQ, 65_000_000, clk frequency in Hz
- BAUD, 115_200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD, truncating division (564 at defaults); elaboration error if CLKS_PER_BIT < 2
- CLICK_BYTE, 8'hC1, payload byte sent per click
- MAX_PENDING, 3, depth of the click queue (clicks waiting, excluding the frame on the wire)

Ports:
- clk  input  1  system clock (65 MHz)
- rst  input  1  asynchronous reset, active high
- click  input  1  1-cycle click pulse, synchronous to clk
- tx_out  output  1  serial line, idle high
- busy  output  1  high while a frame is on the wire (states START/DATA/STOP)
- pending  output  $clog2(MAX_PENDING+1)  clicks queued and not yet started
- dropped  output  1  1-cycle pulse: a click was lost because the queue was full

Behaviour:
- Reset (async assert): tx_out=1, busy=0, pending=0, dropped=0, state IDLE, bit/baud counters 0.
  - Deassertion is synchronous to clk.
  - Reset mid-frame aborts immediately; tx_out=1 is held at least until the first post-reset frame start.
- FSM states: IDLE, START, DATA, STOP.
  - Every bit period is exactly CLKS_PER_BIT cycles, counted by a baud counter that is cleared on each state/bit change.
- IDLE:
  - On an edge with click=1, go to START; tx_out=0 from that edge.
  - Latency is 1 cycle from click sampled to the start-bit edge on the pin.
  - pending is unchanged.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx_out=CLICK_BYTE[idx] for CLKS_PER_BIT cycles per bit; idx runs 0..7.
  - After bit 7, go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. At the end of the period:
  - If pending>0 (after applying any click on that same edge), go to START and decrement pending. There is no extra idle gap beyond the stop bit.
  - Otherwise go to IDLE.
- A full frame is 10*CLKS_PER_BIT cycles. Back-to-back frames are start-to-start spaced by exactly 10*CLKS_PER_BIT.
- Queue (click while busy, or on the STOP→START edge):
  - If pending<MAX_PENDING: pending+1.
  - Else pending unchanged and dropped=1 for that one cycle.
  - Click and frame-launch on the same edge: net pending change is 0; dropped is never asserted in this case.
- Click arriving on the STOP→IDLE edge (pending was 0): counted into pending=1. The next edge then sees IDLE with pending>0 and goes to START, decrementing to 0.
  - Rule: IDLE with pending>0 launches a frame on the next edge, exactly like a click.
- busy is registered: 1 exactly in START/DATA/STOP; 0 in IDLE.
- The block does not debounce or edge-detect; click is assumed to be a clean single-cycle pulse. A held-high click counts once per cycle and is subject to the drop rule.

Test Plan:
- Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000, so CLKS_PER_BIT=10. Default CLICK_BYTE=8'hC1.
- T1 Reset: assert rst asynchronously mid-cycle → tx_out=1, busy=0, pending=0, dropped=0 immediately; hold 5 cycles then release → line stays high.
- T2 Single click: one pulse at cycle 100 →
  - tx_out low from edge 101 for 10 cycles.
  - Then bits 1,0,0,0,0,0,1,1, 10 cycles each.
  - Then stop high for 10 cycles; busy high for exactly 100 cycles.
  - A reference UART decoder reads 0xC1.
- T3 Burst: 3 clicks at cycles 100, 105, 110 →
  - pending reads 1 then 2.
  - Three frames with start bits at edges 101, 201, 301.
  - pending 0 after edge 201+100; no dropped.
- T4 Overflow: 5 clicks during the first frame → pending saturates at 3; dropped pulses exactly once (on the 5th click); exactly 4 frames are emitted.
- T5 Boundaries:
  - Click on the STOP-end edge while pending=2 → next frame starts; pending stays 2.
  - Click on the STOP→IDLE edge → frame starts 1 cycle later.
- T6 Reset mid-DATA: assert rst during bit 4 → tx_out=1 at once, pending=0; a later click produces a clean full frame.
